field_edit_sequencer: RTL and testbench

Controller for the clock screen's time-set mode and alarm flash. Tracks which numeric field group (hour, date, timer) and which of its three digit pairs the user is editing, and drives per-region blanking to the RGB selector so the edited pair blinks. Also runs the RING-word flash sequence when the RTC raises an alarm, with a completion handshake back to the alarm logic. All timing is counted in VGA frames.

---
 rtl/field_edit_sequencer.sv | 168 ++++++++++++++++
 tb/tb_field_edit_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/field_edit_sequencer.sv
// Time-set field editor with blinking blank mask and alarm RING flash sequencer.
// Optional idle auto-exit of edit mode is built when FIELD_EDIT_TIMEOUT_EN is defined.
module field_edit_sequencer #(
  parameter int BLINK_FRAMES   = 30,
  parameter int RING_FRAMES    = 300,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       ring_req,
  output logic       ring_ack,
  output logic       edit_active,
  output logic [1:0] edit_group,
  output logic [1:0] edit_field,
  output logic       blink_phase,
  output logic [8:0] blank_mask,
  output logic       ring_flash
);

  localparam int BW = $clog2(BLINK_FRAMES);
  localparam int RW = (RING_FRAMES > 1) ? $clog2(RING_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_FRAMES - 1);

  typedef enum logic [1:0] {G_NONE, G_HOUR, G_DATE, G_TIMER} group_t;
  typedef enum logic [1:0] {R_IDLE, R_FLASH, R_WAIT} ring_t;

  group_t          group_q, group_d;
  logic [1:0]      field_q, field_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_d;
  ring_t           ring_q, ring_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic            ack_d, flash_d, active_d;
  logic [8:0]      mask_d;
  logic            consumed, accepted, ring_start;
  logic [3:0]      mask_idx;

`ifdef FIELD_EDIT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_FRAMES - 1);
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
`endif

  assign edit_group = group_q;
  assign edit_field = field_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      group_q     <= G_NONE;
      field_q     <= 2'd0;
      blink_cnt_q <= '0;
      blink_phase <= 1'b1;
      ring_q      <= R_IDLE;
      ring_cnt_q  <= '0;
      ring_ack    <= 1'b0;
      ring_flash  <= 1'b0;
      blank_mask  <= 9'd0;
      edit_active <= 1'b0;
`ifdef FIELD_EDIT_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      group_q     <= group_d;
      field_q     <= field_d;
      blink_cnt_q <= blink_cnt_d;
      blink_phase <= phase_d;
      ring_q      <= ring_d;
      ring_cnt_q  <= ring_cnt_d;
      ring_ack    <= ack_d;
      ring_flash  <= flash_d;
      blank_mask  <= mask_d;
      edit_active <= active_d;
`ifdef FIELD_EDIT_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    group_d     = group_q;
    field_d     = field_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = blink_phase;
    ring_d      = ring_q;
    ring_cnt_d  = ring_cnt_q;
    ack_d       = 1'b0;
    consumed    = 1'b0;
    ring_start  = 1'b0;
    mask_d      = 9'd0;
    mask_idx    = 4'd0;

    // Ring sequence: any button during the flash ends it and is swallowed.
    case (ring_q)
      R_IDLE: begin
        if (ring_req) begin
          ring_d     = R_FLASH;
          ring_cnt_d = '0;
          ring_start = 1'b1;
        end
      end
      R_FLASH: begin
        if (btn_mode || btn_next) begin
          ring_d   = R_WAIT;
          ack_d    = 1'b1;
          consumed = 1'b1;
        end else if (frame_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            ring_d = R_WAIT;
            ack_d  = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
      end
      R_WAIT: begin
        if (!ring_req) ring_d = R_IDLE;
      end
      default: ring_d = R_IDLE;
    endcase

    accepted = !consumed && (btn_mode || (btn_next && group_q != G_NONE));

    if (!consumed && btn_mode) begin
      group_d = group_t'(group_q + 2'd1);
      field_d = 2'd0;
    end else if (accepted) begin
      field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
    end

`ifdef FIELD_EDIT_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if (accepted || group_q == G_NONE) begin
      to_cnt_d = '0;
    end else if (frame_tick) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        group_d  = G_NONE;
        field_d  = 2'd0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
`endif

    // A press or ring start restarts the blink so the new state is visible at once.
    if (accepted || ring_start) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~blink_phase;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    active_d = (group_d != G_NONE);
    mask_idx = ({2'b00, group_d} - 4'd1) * 4'd3 + {2'b00, field_d};
    if (active_d && !phase_d) mask_d = 9'd1 << mask_idx;
    flash_d = (ring_d == R_FLASH) && phase_d;
  end

endmodule

// File: tb/tb_field_edit_sequencer.sv
// Bench for field_edit_sequencer: frame-count reference model checked every cycle,
// plus hand-computed literal checks along a directed scenario.
module tb_field_edit_sequencer;
  localparam int BF = 2;
  localparam int RF = 4;
  localparam int TF = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0, btn_mode = 1'b0, btn_next = 1'b0, ring_req = 1'b0;
  logic ring_ack, edit_active, blink_phase, ring_flash;
  logic [1:0] edit_group, edit_field;
  logic [8:0] blank_mask;

  int n_checks = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  field_edit_sequencer #(.BLINK_FRAMES(BF), .RING_FRAMES(RF), .TIMEOUT_FRAMES(TF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_mode(btn_mode),
    .btn_next(btn_next), .ring_req(ring_req), .ring_ack(ring_ack),
    .edit_active(edit_active), .edit_group(edit_group), .edit_field(edit_field),
    .blink_phase(blink_phase), .blank_mask(blank_mask), .ring_flash(ring_flash)
  );

  always #5 clk = ~clk;

  // Reference model: group/field numbers, frames since last blink restart,
  // ring mode (0 idle, 1 flashing, 2 waiting), frames since flash start.
  int m_group, m_field, m_bticks, m_ring, m_rticks, m_idle;
  bit m_ack;

  always @(posedge clk or negedge reset) begin
    bit btn, consumed, accepted, rstart;
    if (!reset) begin
      m_group = 0; m_field = 0; m_bticks = 0; m_ring = 0; m_rticks = 0;
      m_idle = 0; m_ack = 0;
    end else begin
      btn = btn_mode | btn_next;
      rstart = (m_ring == 0) && ring_req;
      consumed = (m_ring == 1) && btn;
      m_ack = 0;
      if (m_ring == 0) begin
        if (ring_req) begin m_ring = 1; m_rticks = 0; end
      end else if (m_ring == 1) begin
        if (btn) begin m_ring = 2; m_ack = 1; end
        else if (frame_tick) begin
          m_rticks++;
          if (m_rticks == RF) begin m_ring = 2; m_ack = 1; end
        end
      end else if (!ring_req) begin
        m_ring = 0;
      end
      accepted = !consumed && (btn_mode || (btn_next && m_group != 0));
      if (!consumed && btn_mode) begin m_group = (m_group + 1) % 4; m_field = 0; end
      else if (accepted) m_field = (m_field + 1) % 3;
`ifdef FIELD_EDIT_TIMEOUT_EN
      if (accepted || m_group == 0) m_idle = 0;
      else if (frame_tick) begin
        m_idle++;
        if (m_idle == TF) begin m_group = 0; m_field = 0; m_idle = 0; end
      end
`endif
      if (accepted || rstart) m_bticks = 0;
      else if (frame_tick) m_bticks++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    bit ph;
    logic [8:0] em;
    if (chk_en) begin
      ph = ((m_bticks / BF) % 2) == 0;
      em = '0;
      if (m_group != 0 && !ph) em[(m_group - 1) * 3 + m_field] = 1'b1;
      chk("model_group", edit_group, m_group);
      chk("model_field", edit_field, m_field);
      chk("model_active", edit_active, m_group != 0);
      chk("model_phase", blink_phase, ph);
      chk("model_mask", blank_mask, em);
      chk("model_flash", ring_flash, (m_ring == 1) && ph);
      chk("model_ack", ring_ack, m_ack);
    end
  end

  task automatic cyc(input logic m, input logic n, input logic t);
    btn_mode = m; btn_next = n; frame_tick = t;
    @(negedge clk);
    btn_mode = 0; btn_next = 0; frame_tick = 0;
  endtask

  initial begin
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_group", edit_group, 0);
    chk("rst_phase", blink_phase, 1);
    chk("rst_mask", blank_mask, 0);
    chk("rst_flash_ack", {ring_flash, ring_ack, edit_active}, 0);
    reset = 1'b1;
    @(negedge clk);

    // group cycling
    cyc(1, 0, 0); chk("grp1", edit_group, 1); chk("grp1_active", edit_active, 1);
    cyc(1, 0, 0); chk("grp2", edit_group, 2);
    cyc(1, 0, 0); chk("grp3", edit_group, 3); chk("grp3_field", edit_field, 0);
    cyc(1, 0, 0); chk("grp0", edit_group, 0); chk("grp0_active", edit_active, 0);

    // field cycling and blink in DATE
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 0); chk("fld1", edit_field, 1); chk("fld1_phase", blink_phase, 1);
    cyc(0, 1, 0); chk("fld2", edit_field, 2); chk("fld2_phase", blink_phase, 1);
    cyc(0, 0, 1); chk("blink_t1_mask", blank_mask, 0);
    cyc(0, 0, 1); chk("blink_t2_mask", blank_mask, 9'b000100000);
    cyc(0, 0, 1); cyc(0, 0, 1); chk("blink_t4_mask", blank_mask, 0);

    // asynchronous reset mid-sequence
    cyc(1, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_group", edit_group, 0);
    chk("arst_phase", blink_phase, 1);
    chk("arst_active", edit_active, 0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // simultaneous buttons
    cyc(1, 0, 0); cyc(0, 1, 0); chk("sim_pre_field", edit_field, 1);
    cyc(1, 1, 0); chk("sim_group", edit_group, 2); chk("sim_field", edit_field, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); chk("sim_back_none", edit_group, 0);

    // ring timeout with ring_req held
    ring_req = 1'b1;
    cyc(0, 0, 0); chk("ring_f0", ring_flash, 1);
    cyc(0, 0, 1); chk("ring_f1", ring_flash, 1);
    cyc(0, 0, 1); chk("ring_f2", ring_flash, 0);
    cyc(0, 0, 1); chk("ring_f3", ring_flash, 0); chk("ring_noack3", ring_ack, 0);
    cyc(0, 0, 1); chk("ring_ack", ring_ack, 1); chk("ring_end_flash", ring_flash, 0);
    cyc(0, 0, 0); chk("ring_ack_1cyc", ring_ack, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
    chk("ring_no_retrig", ring_flash, 0);
    ring_req = 1'b0;
    cyc(0, 0, 0);

    // ring cancelled by a button, which is consumed
    ring_req = 1'b1;
    cyc(0, 0, 0); chk("cancel_pre_flash", ring_flash, 1);
    cyc(1, 0, 0); chk("cancel_ack", ring_ack, 1); chk("cancel_flash", ring_flash, 0);
    chk("cancel_group", edit_group, 0);
    ring_req = 1'b0;
    cyc(0, 0, 0); chk("cancel_ack_off", ring_ack, 0);
    cyc(1, 0, 0); chk("after_ring_mode", edit_group, 1);

    // idle timeout (only exits edit mode when the option is built)
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
`ifdef FIELD_EDIT_TIMEOUT_EN
    chk("timeout_exit", edit_group, 0);
    cyc(1, 0, 0);
`else
    chk("no_timeout", edit_group, 1);
`endif
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 1, 0); cyc(0, 0, 1);
    chk("timeout_held_group", edit_group, 1);
    chk("timeout_held_field", edit_field, 1);
    cyc(0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
